frame_tx: RTL and testbench
===========================

# frame_tx

Serial frame transmitter for the vector display link. It reads a frame of 25-bit points from a point memory and emits it on a UART line using the same framing the display-side receive buffer decodes: an 8-byte zero preamble, 4 bytes per point (MSB first), and a 4-byte `0x01` terminator. It sits on the host/bridge side of the link, or in a loopback test harness driving the receiver directly. The 8N1 bit serializer is built in.

## Interface
- `CLKS_PER_BIT`, 87: clk cycles per UART bit; must be ≥ 2.
- `index_bits`, 11: width of the point index and count.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle request to send a frame; honoured only when `busy`=0.
- `num_points`  in  index_bits  points in the frame; sampled on the accepted `start`.
- `read_address`  out  index_bits  index of the point being fetched.
- `point`  in  25  point data, valid 1 cycle after `read_address` changes. Bit 24 is brightness; bits 23:0 are x/y.
- `tx`  out  1  UART serial out; idles high.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the final stop bit completes.

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0, `read_address`=0. All counters clear and the FSM enters IDLE.
- FSM states: IDLE → PREAMBLE → POINTS → TERM → IDLE.
- IDLE
  - On `start`=1: latch `num_points` as N, set the point counter to 0, go to PREAMBLE.
  - `start` while `busy`=1 is ignored.
- PREAMBLE
  - Send 8 bytes of 0x00.
  - Go to POINTS if N>0, otherwise to TERM.
- POINTS
  - Send N points, 4 bytes each.
  - Word encoding: {2'b00, {6{point[24]}}, point[23:0]}.
  - Byte order: bits 31:24 first, bits 7:0 last.
  - Byte 0 is therefore always 0x00 or 0x3F, so no point can alias the terminator.
- TERM
  - Send 4 bytes of 0x01.
  - Then assert `done` and return to IDLE.
- Prefetch
  - `read_address` = k while point k−1 is being sent (k=0 during PREAMBLE).
  - `point` is captured into the shift word one cycle after each address update.
  - `read_address` holds its last value after the final point and returns to 0 in IDLE.
- Serializer
  - Each byte is 8N1: start bit 0, data bits LSB first, stop bit 1.
  - Each bit lasts exactly `CLKS_PER_BIT` cycles.
  - Consecutive bytes have no gap: the next start bit begins the cycle after the previous stop bit ends.
- Counters
  - The point counter is index_bits wide and compares against N.
  - N is at most 2^index_bits − 1; the counter never wraps.
  - Byte-within-point counter: 2 bits. Preamble counter: 3 bits.
- Edge cases
  - N=0: frame is preamble plus terminator only, and `read_address` stays 0.
  - Reset mid-frame: `tx` is high on the next cycle and the state aborts to IDLE. The receiver recovers by waiting for the next preamble.

## Timing
- `start` is sampled on edge 0.
  - `busy`=1 and `tx`=0 (first start bit) from cycle 1.
- Frame length: F = (12 + 4N)·10·`CLKS_PER_BIT` cycles.
  - `tx` carries the frame during cycles 1 .. F.
  - `done`=1 and `busy`=0 in cycle F+1.
- A new `start` is accepted from cycle F+1 onward (in the same cycle `done` is high).
- `point` must be stable by the cycle after `read_address` changes. This matches a registered-output block RAM.

## Test plan
- N=0, `CLKS_PER_BIT`=4, `start` pulse → decoded bytes 00×8 then 01×4; `done` exactly at cycle 481; `busy` high during cycles 1–480.
- N=2, mem[0]=25'h1_ABCDEF, mem[1]=25'h0_123456 → bytes 00×8, 3F AB CD EF, 00 12 34 56, 01×4.
  - Check `read_address` sequence 0, 1.
  - Check no inter-byte idle cycles.
- Loopback: feed `tx` into the receive buffer with matching bit period and send a 100-point frame.
  - Receiver `num_points`=100.
  - Every point read back equals mem[k], with brightness bit reproduced.
- `start` re-pulsed mid-frame (cycle 200) → ignored; the byte stream is identical to the undisturbed run.
- `reset` asserted mid-point → `tx`=1 the next cycle, `busy`=0, `done` never pulses.
  - A subsequent `start` with N=1 produces a clean complete frame.
- Back-to-back: `start` held high continuously, N=1 → second frame's start bit in cycle F+2. Both frames decode correctly.

Source files
------------

// File: rtl/frame_tx.sv
// Vector display link frame transmitter: streams a zero preamble, the point list
// (4 bytes per point, MSB first) and an 0x01 terminator over a built-in 8N1 UART.
module frame_tx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int index_bits   = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [index_bits-1:0] num_points,
  output logic [index_bits-1:0] read_address,
  input  logic [24:0]           point,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_POINTS, S_TERM} state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_clk_cnt;
  logic [3:0]            r_bit_cnt;
  logic [7:0]            r_byte;
  logic [23:0]           r_word_rest;
  logic [31:0]           r_next_word;
  logic [2:0]            r_pre_cnt;
  logic [1:0]            r_byte_idx;
  logic [index_bits-1:0] r_pt_cnt;
  logic [index_bits-1:0] r_n;
  logic [index_bits-1:0] r_addr;
  logic                  r_fetch_p0;
  logic                  r_fetch_p1;
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_bit_end;
  logic                  w_last_point;
  logic [index_bits:0]   w_pf_addr;
  logic                  w_pf_ok;

  // Brightness is replicated into the top byte so byte 0 is 0x00 or 0x3F,
  // which keeps any point from looking like the 0x01 terminator.
  function automatic logic [31:0] encode_point(input logic [24:0] p);
    return {2'b00, {6{p[24]}}, p[23:0]};
  endfunction

  assign w_bit_end    = (r_clk_cnt == BIT_LAST);
  assign w_last_point = (r_pt_cnt == r_n - 1'b1);
  assign w_pf_addr    = {1'b0, r_pt_cnt} + (index_bits+1)'(2);
  assign w_pf_ok      = (w_pf_addr < {1'b0, r_n});

  assign read_address = r_addr;
  assign tx           = r_tx;
  assign busy         = r_busy;
  assign done         = r_done;

  // Point RAM has a registered output: data for an address issued at edge e
  // is safe to sample at edge e+2, long before the word is needed.
  always_ff @(posedge clk) begin
    if (r_fetch_p1) r_next_word <= encode_point(point);
  end

  always_ff @(posedge clk) begin
    r_done     <= 1'b0;
    r_fetch_p1 <= r_fetch_p0;
    r_fetch_p0 <= 1'b0;
    if (reset) begin
      r_state    <= S_IDLE;
      r_clk_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_pre_cnt  <= '0;
      r_byte_idx <= '0;
      r_pt_cnt   <= '0;
      r_n        <= '0;
      r_addr     <= '0;
      r_fetch_p0 <= 1'b0;
      r_fetch_p1 <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          r_addr <= '0;
          if (start) begin
            r_state    <= S_PREAMBLE;
            r_n        <= num_points;
            r_pt_cnt   <= '0;
            r_pre_cnt  <= '0;
            r_byte_idx <= '0;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_byte     <= 8'h00;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
            r_fetch_p0 <= 1'b1;
          end
        end
        default: begin
          if (!w_bit_end) begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end else begin
            r_clk_cnt <= '0;
            if (r_bit_cnt != 4'd9) begin
              // bit 0 is the start bit, 1..8 carry data LSB first, 9 is the stop bit
              r_bit_cnt <= r_bit_cnt + 4'd1;
              r_tx      <= (r_bit_cnt == 4'd8) ? 1'b1 : r_byte[r_bit_cnt[2:0]];
            end else begin
              // Stop bit finished: the next byte's start bit follows with no gap.
              r_bit_cnt <= '0;
              r_tx      <= 1'b0;
              case (r_state)
                S_PREAMBLE: begin
                  if (r_pre_cnt == 3'd7) begin
                    r_byte_idx <= '0;
                    if (r_n != '0) begin
                      r_state     <= S_POINTS;
                      r_byte      <= r_next_word[31:24];
                      r_word_rest <= r_next_word[23:0];
                      if (r_n > index_bits'(1)) begin
                        r_addr     <= index_bits'(1);
                        r_fetch_p0 <= 1'b1;
                      end
                    end else begin
                      r_state <= S_TERM;
                      r_byte  <= 8'h01;
                    end
                  end else begin
                    r_pre_cnt <= r_pre_cnt + 3'd1;
                    r_byte    <= 8'h00;
                  end
                end
                S_POINTS: begin
                  if (r_byte_idx == 2'd3) begin
                    r_byte_idx <= '0;
                    if (w_last_point) begin
                      r_state <= S_TERM;
                      r_byte  <= 8'h01;
                    end else begin
                      r_pt_cnt    <= r_pt_cnt + 1'b1;
                      r_byte      <= r_next_word[31:24];
                      r_word_rest <= r_next_word[23:0];
                      if (w_pf_ok) begin
                        r_addr     <= w_pf_addr[index_bits-1:0];
                        r_fetch_p0 <= 1'b1;
                      end
                    end
                  end else begin
                    r_byte_idx  <= r_byte_idx + 2'd1;
                    r_byte      <= r_word_rest[23:16];
                    r_word_rest <= {r_word_rest[15:0], 8'h00};
                  end
                end
                S_TERM: begin
                  if (r_byte_idx == 2'd3) begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_addr  <= '0;
                  end else begin
                    r_byte_idx <= r_byte_idx + 2'd1;
                    r_byte     <= 8'h01;
                  end
                end
                default: r_state <= S_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_tx.sv
// Randomized scoreboard bench for frame_tx: a UART decoder checks every byte's
// value and start cycle against a frame model built from the point memory.
`timescale 1ns/1ps
module tb_frame_tx;
  localparam int CPB      = 4;
  localparam int IB       = 11;
  localparam int BYTE_CYC = 10 * CPB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [IB-1:0] num_points = '0;
  logic [IB-1:0] read_address;
  logic [24:0]   point;
  logic          tx, busy, done;

  logic [24:0] mem [0:(1<<IB)-1];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int epoch = 0;

  typedef struct { logic [7:0] val; int at; } exp_t;
  exp_t          bq[$];
  int            dq[$];
  logic [IB-1:0] alog[$];

  frame_tx #(.CLKS_PER_BIT(CPB), .index_bits(IB)) dut (
    .clk(clk), .reset(reset), .start(start), .num_points(num_points),
    .read_address(read_address), .point(point), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) point <= mem[read_address];

  always @(negedge clk)
    if (busy === 1'b1 && (alog.size() == 0 || alog[$] != read_address))
      alog.push_back(read_address);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int frame_len(input int n);
    return (12 + 4 * n) * BYTE_CYC;
  endfunction

  // Frame model: preamble, point bytes from memory, terminator, back to back.
  task automatic push_frame(input int n, input int t0);
    logic [7:0] b[$];
    exp_t e;
    for (int i = 0; i < 8; i++) b.push_back(8'h00);
    for (int k = 0; k < n; k++) begin
      b.push_back(mem[k][24] ? 8'h3F : 8'h00);
      b.push_back(mem[k][23:16]);
      b.push_back(mem[k][15:8]);
      b.push_back(mem[k][7:0]);
    end
    for (int i = 0; i < 4; i++) b.push_back(8'h01);
    for (int j = 0; j < b.size(); j++) begin
      e.val = b[j];
      e.at  = t0 + 1 + j * BYTE_CYC;
      bq.push_back(e);
    end
    dq.push_back(t0 + 1 + b.size() * BYTE_CYC);
  endtask

  initial begin : decoder
    int c0, ep;
    logic [9:0] bits;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && tx === 1'b0) begin
        c0 = cyc;
        ep = epoch;
        for (int i = 0; i < 10; i++) begin
          while (cyc < c0 + i * CPB + CPB / 2) @(negedge clk);
          bits[i] = tx;
        end
        while (cyc < c0 + BYTE_CYC - 1) @(negedge clk);
        if (ep == epoch) begin
          checks++;
          if (bq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_byte got %02h at cycle %0d, want none", bits[8:1], c0);
          end else begin
            e = bq.pop_front();
            if (bits[0] !== 1'b0 || bits[9] !== 1'b1 || bits[8:1] !== e.val) begin
              errors++;
              $display("FAIL byte got frame %03h want data %02h (cycle %0d)", bits, e.val, c0);
            end
            checks++;
            if (c0 != e.at) begin
              errors++;
              $display("FAIL byte_start got cycle %0d want %0d", c0, e.at);
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin : donemon
    int d;
    if (done === 1'b1) begin
      checks++;
      if (dq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done got pulse at cycle %0d want none", cyc);
      end else begin
        d = dq.pop_front();
        if (d != cyc || busy !== 1'b0) begin
          errors++;
          $display("FAIL done_timing got cycle %0d busy %b want cycle %0d busy 0", cyc, busy, d);
        end
      end
    end
  end

  task automatic launch(input int n);
    num_points = IB'(n);
    start = 1'b1;
    alog.delete();
    push_frame(n, cyc);
  endtask

  task automatic run_frame(input int n, input int repulse_at);
    int t0, f;
    bit busy_gap;
    t0 = cyc;
    f  = frame_len(n);
    launch(n);
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", busy, 1);
    check("tx_first_start", tx, 0);
    busy_gap = 0;
    while (cyc < t0 + f) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_gap = 1;
      if (repulse_at != 0 && cyc == t0 + repulse_at) begin
        start = 1'b1;
        num_points = IB'(n + 5);
      end else begin
        start = 1'b0;
      end
    end
    check("busy_window", busy_gap, 0);
    @(negedge clk);
    check("done_pulse", done, 1);
    check("busy_fall", busy, 0);
    @(negedge clk);
    check("addr_idle", read_address, 0);
    check("addr_seq_len", alog.size(), (n == 0) ? 1 : n);
    for (int k = 0; k < alog.size(); k++) check("addr_seq", alog[k], k);
    check("bytes_drained", bq.size(), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got no finish by cycle %0d want completion", cyc);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, f, n;
    for (int i = 0; i < (1 << IB); i++) mem[i] = 25'($urandom);
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_addr", read_address, 0);
    reset = 1'b0;
    @(negedge clk);

    run_frame(0, 0);

    mem[0] = 25'h1_ABCDEF;
    mem[1] = 25'h0_123456;
    run_frame(2, 0);

    for (int k = 0; k < 100; k++) mem[k] = 25'($urandom);
    run_frame(100, 0);

    run_frame(3, 200);

    // Reset in the middle of the first point, then a clean N=1 frame.
    t0 = cyc;
    launch(4);
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 1 + 9 * BYTE_CYC + 13) @(negedge clk);
    reset = 1'b1;
    epoch++;
    bq.delete();
    dq.delete();
    @(negedge clk);
    reset = 1'b0;
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    repeat (3 * BYTE_CYC) @(negedge clk);
    check("abort_quiet_tx", tx, 1);
    check("abort_quiet_busy", busy, 0);
    run_frame(1, 0);

    // start held high: second frame is accepted the cycle done pulses.
    mem[0] = 25'($urandom);
    t0 = cyc;
    f  = frame_len(1);
    launch(1);
    push_frame(1, t0 + f + 1);
    while (cyc < t0 + f + 2) @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 2 * f + 4) @(negedge clk);
    check("b2b_done_drained", dq.size(), 0);
    check("b2b_bytes_drained", bq.size(), 0);

    repeat (4) begin
      n = $urandom_range(0, 6);
      for (int k = 0; k < n; k++) mem[k] = 25'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_frame(n, 0);
    end

    check("final_bytes_empty", bq.size(), 0);
    check("final_done_empty", dq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
